// File: rtl/mem_access_unit.sv
// Load/store unit between a single requester and a big-endian byte-addressed
// data memory. One request in flight; sub-word stores use read-modify-write.
module mem_access_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_r,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [31:0]         mwdata_q, mwdata_d;
  logic                req_err;

  // The addressed byte is the most significant byte of the memory word
  // (big-endian), so sub-word loads take the top of mem_rdata.
  function automatic logic [31:0] load_ext(input logic [31:0] r,
                                           input logic [1:0] sz,
                                           input logic sgn);
    logic [31:0] v;
    case (sz)
      SZ_BYTE: v = sgn ? {{24{r[31]}}, r[31:24]} : {24'h0, r[31:24]};
      SZ_HALF: v = sgn ? {{16{r[31]}}, r[31:16]} : {16'h0, r[31:16]};
      default: v = r;
    endcase
    return v;
  endfunction

  // Replace the leading bytes of the old word with the right-justified store data.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] w,
                                        input logic [1:0] sz);
    logic [31:0] v;
    case (sz)
      SZ_BYTE: v = {w[7:0], old[23:0]};
      SZ_HALF: v = {w[15:0], old[15:0]};
      default: v = w;
    endcase
    return v;
  endfunction

  assign req_err = (req_size == 2'b11) ||
                   (req_size == SZ_HALF && req_addr[0]) ||
                   (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

  // Next state and per-state handshake / memory strobes.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_r      = 1'b0;
    mem_wr     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                 state_d = RESP;
          else if (!req_we)            state_d = RD;
          else if (req_size == SZ_WORD) state_d = WR;
          else                         state_d = RMW_RD;
        end
      end
      RD:     begin mem_r  = 1'b1; state_d = RESP; end
      RMW_RD: begin mem_r  = 1'b1; state_d = WR;   end
      WR:     begin mem_wr = 1'b1; state_d = RESP; end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, load result in RD, merged write word in RMW_RD.
  // mem_addr/mem_wdata only move when a new access is set up, so they hold otherwise.
  always_comb begin
    size_d   = size_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        size_d   = req_size;
        signed_d = req_signed;
        wdata_d  = req_wdata;
        err_d    = req_err;
        rdata_d  = '0;
        if (!req_err) begin
          maddr_d = req_addr;
          if (req_we && req_size == SZ_WORD) mwdata_d = req_wdata;
        end
      end
      RD:      rdata_d  = load_ext(mem_rdata, size_q, signed_q);
      RMW_RD:  mwdata_d = merge(mem_rdata, wdata_q, size_q);
      default: ;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      size_q   <= '0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_W, 12, byte-address width of the data memory (4 KB space).
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: req_valid  input  1  requester presents a load/store.
REQ-005 Port: req_ready  output  1  unit can accept a request this cycle.
REQ-006 Port: req_we  input  1  1 = store, 0 = load.
REQ-007 Port: req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 Port: req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 Port: req_addr  input  ADDR_W  byte address.
REQ-010 Port: req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 Port: resp_valid  output  1  response available.
REQ-012 Port: resp_ready  input  1  requester accepts response.
REQ-013 Port: resp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 Port: resp_err  output  1  misaligned or reserved-size request.
REQ-015 Port: mem_addr  output  ADDR_W  byte address to data memory.
REQ-016 Port: mem_wr  output  1  memory write strobe.
REQ-017 Port: mem_r  output  1  memory read enable.
REQ-018 Port: mem_wdata  output  32  4 bytes written big-endian at mem_addr..mem_addr+3.
REQ-019 Port: mem_rdata  input  32  4 bytes read big-endian from mem_addr..mem_addr+3, combinational.

Function
REQ-020 States SHALL be IDLE, RD, RMW_RD, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 Request accepted on edge with req_valid & req_ready; addr, size, signed, we, wdata captured in registers.
REQ-022 Error on accept: size 11, or half with addr[0]=1, or word with addr[1:0]!=00 -> RESP with resp_err=1, rdata 0, no memory access.
REQ-023 Valid load -> RD; valid word store -> WR; valid byte/half store -> RMW_RD.
REQ-024 RD: mem_r=1, mem_addr=captured addr for exactly one cycle; mem_rdata registered at end of cycle; -> RESP.
REQ-025 Load extraction: byte = mem_rdata[31:24], half = mem_rdata[31:16], word = mem_rdata; extend to 32 bits per req_signed.
REQ-026 RMW_RD: mem_r=1 one cycle, mem_rdata registered; -> WR.
REQ-027 WR merge: byte store writes {wdata[7:0], old[23:0]}; half store writes {wdata[15:0], old[15:0]}; word store writes wdata.
REQ-028 WR: mem_wr=1 for exactly one cycle with mem_addr/mem_wdata stable; -> RESP.
REQ-029 mem_wr and mem_r SHALL never both be 1; both 0 in IDLE and RESP.
REQ-030 RESP: resp_valid=1, resp_rdata/resp_err held stable until resp_ready=1; on that edge -> IDLE.
REQ-031 Latency from accept edge to resp_valid: error 1 cycle, load 2, word store 2, sub-word store 3 (resp_ready tied high).
REQ-032 Address arithmetic SHALL not check for wrap; addr 0xFFC word access is legal (memory wraps mod 4096).
REQ-033 New request SHALL NOT be accepted in the cycle a response is consumed; next accept earliest in following IDLE cycle.
REQ-034 mem_addr/mem_wdata hold last driven values outside RD/RMW_RD/WR.

Reset
REQ-035 rst=1 at an edge SHALL force IDLE from any state; in-flight request dropped, no response issued.
REQ-036 After reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_wr=0, mem_r=0, mem_addr=0, mem_wdata=0.
REQ-037 Reset asserted during WR SHALL deassert mem_wr on the reset edge.

Verification
REQ-038 Word store addr 0x010 data 0xDEADBEEF, then word load 0x010 -> mem_wr one cycle with mem_wdata 0xDEADBEEF; load resp_rdata 0xDEADBEEF, resp_err 0, 2-cycle latency.
REQ-039 Byte store addr 0x011 data 0x000000AA over 0x11223344 at 0x011 -> RMW read then write 0xAA223344; signed byte load 0x011 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-040 Half load addr 0x013 (odd) and word load 0x012 -> resp_err 1, resp_rdata 0, mem_r/mem_wr never asserted, 1-cycle latency.
REQ-041 resp_ready held 0 for 5 cycles after load -> resp_valid and resp_rdata stable throughout, req_ready 0; resp_ready 1 -> IDLE next cycle.
REQ-042 rst pulsed during RMW_RD of half store -> no mem_wr, no resp_valid, outputs at reset values, next request served normally.
REQ-043 Back-to-back requests with req_valid held high -> mem_wr & mem_r never both 1; each request gets exactly one response in order.
